riscv_trace_capture: RTL and testbench

//  Synthesizable retire-trace collector for the RISC-V core debug path.
//  - Merges each instruction-retire event with the data-bus access made by that instruction.
//  - Buffers the merged records in a FIFO with a valid/ready output.
//  - Replaces per-testbench trace glue with one parametrised block that can sit in DUT or bench.
//  - Feeds riscv_debug_bfm or an on-chip trace sink.

---
 rtl/riscv_trace_capture.sv | 199 +++++++++++++++++++
 tb/tb_riscv_trace_capture.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_capture.sv
// Retire-trace collector: merges each retire with its data-bus access and queues the
// records in a first-word-fall-through FIFO. Optional macro: TRACE_TIMESTAMP_EN.
module riscv_trace_capture #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 8,
    parameter  int TS_WIDTH   = 32,
    localparam int STRB       = DATA_WIDTH / 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ret_valid,
    input  logic [31:0]           ret_instr,
    input  logic [ADDR_WIDTH-1:0] ret_pc,
    input  logic                  ret_trap,
    input  logic [4:0]            ret_rd_addr,
    input  logic [DATA_WIDTH-1:0] ret_rd_wdata,
    input  logic                  mem_valid,
    input  logic                  mem_ready,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_size,
    input  logic [STRB-1:0]       mem_wstb,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  trc_valid,
    input  logic                  trc_ready,
    output logic [31:0]           trc_instr,
    output logic [ADDR_WIDTH-1:0] trc_pc,
    output logic                  trc_trap,
    output logic [4:0]            trc_rd_addr,
    output logic [DATA_WIDTH-1:0] trc_rd_wdata,
    output logic [ADDR_WIDTH-1:0] trc_mem_addr,
    output logic [STRB-1:0]       trc_mem_rmask,
    output logic [STRB-1:0]       trc_mem_wmask,
    output logic [DATA_WIDTH-1:0] trc_mem_data,
    output logic [TS_WIDTH-1:0]   trc_timestamp,
    output logic [LVL_W-1:0]      fifo_level,
    output logic [15:0]           drop_cnt
);

    localparam int OFF_W = $clog2(STRB);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRB-1:0]       rmask;
        logic [STRB-1:0]       wmask;
        logic [DATA_WIDTH-1:0] data;
    } acc_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  trap;
        logic [4:0]            rd_addr;
        logic [DATA_WIDTH-1:0] rd_wdata;
        acc_t                  acc;
    } rec_t;

    // Size-aligned byte mask; sizes wider than the bus clip to the full bus.
    function automatic logic [STRB-1:0] load_mask(input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off);
        logic [15:0]      ones;
        logic [3:0]       nb_m1;
        logic [OFF_W-1:0] align;
        logic [15:0]      shifted;
        ones    = (16'd1 << (5'd1 << size)) - 16'd1;
        nb_m1   = (4'd1 << size) - 4'd1;
        align   = off & ~nb_m1[OFF_W-1:0];
        shifted = ones << align;
        return shifted[STRB-1:0];
    endfunction

    logic             hs;
    acc_t             hs_acc;
    acc_t             use_acc;
    acc_t             pend_d, pend_q;
    rec_t             rec_d;
    rec_t             head;
    rec_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [LVL_W-1:0] level_d, level_q;
    logic [15:0]      drop_d, drop_q;
    logic             full, pop, push, drop;

    assign trc_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        hs          = mem_valid & mem_ready;
        hs_acc      = '0;
        hs_acc.addr = mem_addr;
        if (mem_write) begin
            hs_acc.wmask = mem_wstb;
            hs_acc.data  = mem_wdata;
        end else begin
            hs_acc.rmask = load_mask(mem_size, mem_addr[OFF_W-1:0]);
            hs_acc.data  = mem_rdata;
        end
        use_acc = hs ? hs_acc : pend_q;

        // An all-zero pending entry doubles as "no access".
        pend_d = pend_q;
        if (ret_valid) begin
            pend_d = '0;
        end else if (hs) begin
            pend_d = hs_acc;
        end

        rec_d.instr    = ret_instr;
        rec_d.pc       = ret_pc;
        rec_d.trap     = ret_trap;
        rec_d.rd_addr  = ret_rd_addr;
        rec_d.rd_wdata = ret_rd_wdata;
        rec_d.acc      = use_acc;

        pop  = trc_valid & trc_ready;
        full = (level_q == LVL_W'(FIFO_DEPTH));
        push = ret_valid & (~full | pop);
        drop = ret_valid & full & ~pop;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        drop_d   = drop_q;
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rec_d;
        end
    end

    // Outputs read zero whenever the FIFO is empty, including straight out of reset.
    always_comb begin
        head = trc_valid ? mem_q[rd_ptr_q] : '0;
    end

    assign trc_instr     = head.instr;
    assign trc_pc        = head.pc;
    assign trc_trap      = head.trap;
    assign trc_rd_addr   = head.rd_addr;
    assign trc_rd_wdata  = head.rd_wdata;
    assign trc_mem_addr  = head.acc.addr;
    assign trc_mem_rmask = head.acc.rmask;
    assign trc_mem_wmask = head.acc.wmask;
    assign trc_mem_data  = head.acc.data;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_d, ts_q;
    logic [TS_WIDTH-1:0] ts_mem_q [FIFO_DEPTH];

    always_comb begin
        ts_d = ts_q + TS_WIDTH'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ts_mem_q[wr_ptr_q] <= ts_q;
        end
    end

    assign trc_timestamp = trc_valid ? ts_mem_q[rd_ptr_q] : '0;
`else
    assign trc_timestamp = '0;
`endif

endmodule

// File: tb/tb_riscv_trace_capture.sv
// Scoreboard bench for riscv_trace_capture: directed scenarios plus randomized traffic
// checked against a transaction-level model of merge, FIFO occupancy and drops.
module tb_riscv_trace_capture;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TSW   = 32;
    localparam int STRB  = DW / 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            ret_valid;
    logic [31:0]     ret_instr;
    logic [AW-1:0]   ret_pc;
    logic            ret_trap;
    logic [4:0]      ret_rd_addr;
    logic [DW-1:0]   ret_rd_wdata;
    logic            mem_valid;
    logic            mem_ready;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [1:0]      mem_size;
    logic [STRB-1:0] mem_wstb;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            trc_valid;
    logic            trc_ready;
    logic [31:0]     trc_instr;
    logic [AW-1:0]   trc_pc;
    logic            trc_trap;
    logic [4:0]      trc_rd_addr;
    logic [DW-1:0]   trc_rd_wdata;
    logic [AW-1:0]   trc_mem_addr;
    logic [STRB-1:0] trc_mem_rmask;
    logic [STRB-1:0] trc_mem_wmask;
    logic [DW-1:0]   trc_mem_data;
    logic [TSW-1:0]  trc_timestamp;
    logic [3:0]      fifo_level;
    logic [15:0]     drop_cnt;

    always #5 clock = ~clock;

    riscv_trace_capture #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ret_valid(ret_valid), .ret_instr(ret_instr), .ret_pc(ret_pc), .ret_trap(ret_trap),
        .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wstb(mem_wstb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_instr(trc_instr), .trc_pc(trc_pc),
        .trc_trap(trc_trap), .trc_rd_addr(trc_rd_addr), .trc_rd_wdata(trc_rd_wdata),
        .trc_mem_addr(trc_mem_addr), .trc_mem_rmask(trc_mem_rmask),
        .trc_mem_wmask(trc_mem_wmask), .trc_mem_data(trc_mem_data),
        .trc_timestamp(trc_timestamp), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        trap;
        logic [4:0]  rd;
        logic [31:0] rd_wdata;
        logic [31:0] maddr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] mdata;
        logic [31:0] ts;
    } rec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] data;
    } acc_t;

    rec_t        exp_q[$];
    rec_t        mon_got;
    rec_t        mon_exp;
    int          checks   = 0;
    int          errors   = 0;
    int          recv_cnt = 0;
    int          m_level  = 0;
    int          m_drop   = 0;
    acc_t        m_pend   = '0;
    logic [31:0] ts_model;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ts_model <= '0;
        else          ts_model <= ts_model + 32'd1;
    end

    // Load mask from first principles: n bytes starting at the offset rounded down to n.
    function automatic logic [3:0] ref_rmask(input logic [1:0] size, input logic [31:0] addr);
        int         n;
        int         start;
        logic [3:0] m;
        n     = 1 << size;
        start = (int'(addr % 4) / n) * n;
        m     = '0;
        for (int b = start; b < start + n; b++) begin
            if (b < 4) m[b] = 1'b1;
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && trc_valid && trc_ready) begin
            mon_got.instr    = trc_instr;
            mon_got.pc       = trc_pc;
            mon_got.trap     = trc_trap;
            mon_got.rd       = trc_rd_addr;
            mon_got.rd_wdata = trc_rd_wdata;
            mon_got.maddr    = trc_mem_addr;
            mon_got.rmask    = trc_mem_rmask;
            mon_got.wmask    = trc_mem_wmask;
            mon_got.mdata    = trc_mem_data;
            mon_got.ts       = trc_timestamp;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL record_unexpected: got %h expected no record", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                recv_cnt++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL record: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    // Applies the current inputs for one clock, updates the model, then checks occupancy.
    task automatic step();
        acc_t acc;
        acc_t used;
        rec_t r;
        logic hs, pop, full, push;
        hs  = mem_valid && mem_ready;
        acc = '0;
        if (hs) begin
            acc.addr = mem_addr;
            if (mem_write) begin
                acc.wmask = mem_wstb;
                acc.data  = mem_wdata;
            end else begin
                acc.rmask = ref_rmask(mem_size, mem_addr);
                acc.data  = mem_rdata;
            end
        end
        used = hs ? acc : m_pend;
        if (ret_valid)  m_pend = '0;
        else if (hs)    m_pend = acc;
        pop  = (m_level > 0) && trc_ready;
        full = (m_level == DEPTH);
        push = ret_valid && (!full || pop);
        if (ret_valid && !push && m_drop < 65535) m_drop++;
        if (push) begin
            r.instr    = ret_instr;
            r.pc       = ret_pc;
            r.trap     = ret_trap;
            r.rd       = ret_rd_addr;
            r.rd_wdata = ret_rd_wdata;
            r.maddr    = used.addr;
            r.rmask    = used.rmask;
            r.wmask    = used.wmask;
            r.mdata    = used.data;
`ifdef TRACE_TIMESTAMP_EN
            r.ts       = ts_model;
`else
            r.ts       = '0;
`endif
            exp_q.push_back(r);
        end
        m_level += int'(push) - int'(pop);
        @(posedge clock);
        #1;
        chk("fifo_level", 64'(fifo_level), 64'(m_level));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("trc_valid", 64'(trc_valid), 64'(m_level > 0));
    endtask

    task automatic idle();
        ret_valid = 1'b0;
        mem_valid = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic set_ret();
        ret_valid    = 1'b1;
        ret_instr    = $urandom;
        ret_pc       = $urandom;
        ret_trap     = ($urandom_range(0, 9) == 0);
        ret_rd_addr  = 5'($urandom_range(0, 31));
        ret_rd_wdata = $urandom;
    endtask

    task automatic rand_cycle(input int ready_pct);
        ret_valid    = ($urandom_range(0, 99) < 55);
        ret_instr    = $urandom;
        ret_pc       = $urandom;
        ret_trap     = ($urandom_range(0, 9) == 0);
        ret_rd_addr  = 5'($urandom_range(0, 31));
        ret_rd_wdata = $urandom;
        mem_valid    = ($urandom_range(0, 99) < 50);
        mem_ready    = ($urandom_range(0, 99) < 70);
        mem_write    = 1'($urandom_range(0, 1));
        mem_addr     = $urandom;
        mem_size     = 2'($urandom_range(0, 3));
        mem_wstb     = 4'($urandom_range(0, 15));
        mem_wdata    = $urandom;
        mem_rdata    = $urandom;
        trc_ready    = ($urandom_range(0, 99) < ready_pct);
        step();
    endtask

    task automatic drain();
        int guard;
        idle();
        trc_ready = 1'b1;
        guard = 0;
        while (m_level > 0 && guard < 50) begin
            step();
            guard++;
        end
        chk("drain_done", 64'(m_level), 64'd0);
    endtask

    task automatic wait_ts(input logic [31:0] target);
        int guard;
        guard = 0;
        idle();
        while (ts_model != target && guard < 40) begin
            step();
            guard++;
        end
        chk("ts_wait", 64'(ts_model), 64'(target));
    endtask

    initial begin
        int start_cnt;
        logic [31:0] exp_ts5;
        reset_n      = 1'b0;
        trc_ready    = 1'b0;
        ret_valid    = 1'b0;
        ret_instr    = '0;
        ret_pc       = '0;
        ret_trap     = 1'b0;
        ret_rd_addr  = '0;
        ret_rd_wdata = '0;
        mem_valid    = 1'b0;
        mem_ready    = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_size     = '0;
        mem_wstb     = '0;
        mem_wdata    = '0;
        mem_rdata    = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 64'(trc_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_instr", 64'(trc_instr), 64'd0);
        chk("rst_ts", 64'(trc_timestamp), 64'd0);
        reset_n = 1'b1;

        // Timestamps of retires at cycles 5 and 9 after reset release.
        wait_ts(32'd5);
        set_ret();
        step();
`ifdef TRACE_TIMESTAMP_EN
        exp_ts5 = 32'd5;
`else
        exp_ts5 = 32'd0;
`endif
        chk("ts_first_head", 64'(trc_timestamp), 64'(exp_ts5));
        wait_ts(32'd9);
        set_ret();
        step();
        drain();

        // Load, idle cycle, then retire.
        trc_ready = 1'b0;
        mem_valid = 1'b1; mem_ready = 1'b1; mem_write = 1'b0;
        mem_addr  = 32'h1002; mem_size = 2'd1; mem_rdata = 32'hAABB0000;
        step();
        idle();
        step();
        set_ret();
        step();
        chk("load_rmask", 64'(trc_mem_rmask), 64'hC);
        chk("load_data", 64'(trc_mem_data), 64'hAABB0000);
        chk("load_wmask", 64'(trc_mem_wmask), 64'd0);
        chk("load_addr", 64'(trc_mem_addr), 64'h1002);
        drain();

        // Store handshake in the retire cycle, then a retire with no access.
        trc_ready = 1'b0;
        set_ret();
        mem_valid = 1'b1; mem_ready = 1'b1; mem_write = 1'b1;
        mem_addr  = 32'h2000; mem_wstb = 4'b0001; mem_wdata = 32'h55;
        step();
        chk("store_wmask", 64'(trc_mem_wmask), 64'd1);
        chk("store_data", 64'(trc_mem_data), 64'h55);
        chk("store_rmask", 64'(trc_mem_rmask), 64'd0);
        idle();
        set_ret();
        step();
        idle();
        trc_ready = 1'b1;
        step();
        trc_ready = 1'b0;
        chk("noacc_wmask", 64'(trc_mem_wmask), 64'd0);
        chk("noacc_data", 64'(trc_mem_data), 64'd0);
        chk("noacc_addr", 64'(trc_mem_addr), 64'd0);
        drain();

        // Overflow: ten retires into a stalled FIFO, then pop+push while full.
        trc_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_ret();
            step();
        end
        chk("ovf_level", 64'(fifo_level), 64'd8);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        trc_ready = 1'b1;
        set_ret();
        step();
        chk("full_pushpop_level", 64'(fifo_level), 64'd8);
        chk("full_pushpop_drop", 64'(drop_cnt), 64'd2);
        idle();
        repeat (5) step();

        // Asynchronous reset with three records still queued.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(trc_valid), 64'd0);
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_instr", 64'(trc_instr), 64'd0);
        exp_q.delete();
        m_level = 0;
        m_drop  = 0;
        m_pend  = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Back-to-back retires into an always-ready sink.
        start_cnt = recv_cnt;
        trc_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_ret();
            step();
            chk("b2b_level_le1", 64'(fifo_level <= 4'd1), 64'd1);
        end
        drain();
        chk("b2b_count", 64'(recv_cnt - start_cnt), 64'd20);
        chk("b2b_drop", 64'(drop_cnt), 64'd0);

        for (int i = 0; i < 250; i++) rand_cycle(30);
        for (int i = 0; i < 250; i++) rand_cycle(85);
        drain();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
